i2s_capture_ctrl: RTL

Capture sequencer placed directly behind the I2S receiver in the audio ingest path. It arms on a software start, aligns to a left-channel word, and pairs left and right words into stereo frames. Frames are buffered in a small FIFO and delivered as fixed-length packets over a valid/ready stream to the Ethernet packetiser. On stop, a partial packet is zero-padded so downstream always sees whole packets.

---
 rtl/i2s_cap_pkg.sv | 21 ++
 rtl/i2s_cap_fifo.sv | 53 +++++
 rtl/i2s_capture_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/i2s_cap_pkg.sv
// Shared state encoding and width helper for the I2S capture sequencer.
package i2s_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_CAP   = 2'd2,
    ST_DRAIN = 2'd3
  } cap_state_t;

  // Ceiling log2; LOG2(1) = 0.
  function automatic int LOG2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_cap_fifo.sv
// Synchronous FIFO for stereo frames; read data is zero whenever the FIFO is empty
// so the stream outputs stay at 0 after reset.
module i2s_cap_fifo
  import i2s_cap_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [WIDTH-1:0]     i_wdata,
  output logic [WIDTH-1:0]     o_rdata,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [LOG2(DEPTH):0] o_level
);

  localparam int AW = LOG2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_level <= r_level + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_level <= r_level - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/i2s_capture_ctrl.sv
// I2S capture sequencer: pairs left/right words into frames and emits fixed-length
// zero-padded packets. Define I2S_CAP_OVF_CNT_EN to add the ovf_cnt dropped-frame counter.
module i2s_capture_ctrl
  import i2s_cap_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_LEN    = 64
) (
  input  logic                      sck,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [DATA_WIDTH-1:0]     i2s_data,
  input  logic                      i2s_l_vld,
  input  logic                      i2s_r_vld,
  output logic [2*DATA_WIDTH-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      busy,
  output logic                      ovf,
`ifdef I2S_CAP_OVF_CNT_EN
  output logic [15:0]               ovf_cnt,
`endif
  output logic [LOG2(FIFO_DEPTH):0] level
);

  localparam int FW    = 2*DATA_WIDTH + 1;
  localparam int CNT_W = LOG2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

  cap_state_t            r_state;
  cap_state_t            w_next;
  logic [DATA_WIDTH-1:0] r_left;
  logic                  r_have_left;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf;

  logic          w_arm_entry, w_latch_left, w_frame, w_wr_frame, w_drop, w_pad;
  logic          w_push, w_last, w_full, w_empty;
  logic [FW-1:0] w_wdata, w_rdata;

  assign w_arm_entry  = (r_state == ST_IDLE) & start;
  assign w_latch_left = ((r_state == ST_ARM) & i2s_l_vld & ~stop) |
                        ((r_state == ST_CAP) & i2s_l_vld & ~i2s_r_vld & ~stop);
  // A frame coinciding with stop is discarded; stop wins.
  assign w_frame      = (r_state == ST_CAP) & i2s_r_vld & ~i2s_l_vld & r_have_left & ~stop;
  assign w_wr_frame   = w_frame & ~w_full;
  assign w_drop       = w_frame & w_full;
  assign w_pad        = (r_state == ST_DRAIN) & (r_cnt != '0) & ~w_full;
  assign w_push       = w_wr_frame | w_pad;
  assign w_last       = (r_cnt == LAST_CNT);
  assign w_wdata      = w_pad ? {{(2*DATA_WIDTH){1'b0}}, w_last} : {r_left, i2s_data, w_last};

  always_ff @(posedge sck) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_ARM;
      ST_ARM:   if (stop) w_next = ST_IDLE;
                else if (i2s_l_vld) w_next = ST_CAP;
      ST_CAP:   if (stop) w_next = ST_DRAIN;
      ST_DRAIN: if ((r_cnt == '0) && w_empty) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
  end

  always_ff @(posedge sck) begin
    if (!rst_n) begin
      r_have_left <= 1'b0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
    end else if (w_arm_entry) begin
      r_have_left <= 1'b0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_latch_left) r_have_left <= 1'b1;
      else if (w_frame) r_have_left <= 1'b0;
      if (w_push)       r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      if (w_drop)       r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge sck) begin
    if (w_arm_entry)       r_left <= '0;
    else if (w_latch_left) r_left <= i2s_data;
  end

`ifdef I2S_CAP_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge sck) begin
    if (!rst_n || w_arm_entry)               r_ovf_cnt <= '0;
    else if (w_drop && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  i2s_cap_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sck),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_pop   (m_ready),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign m_valid = ~w_empty;
  assign m_data  = w_rdata[FW-1:1];
  assign m_last  = w_rdata[0];
  assign ovf     = r_ovf;

endmodule
